idle_watchdog: RTL and testbench

- Tracks user inactivity on the alarm clock and signals when the idle time reaches a programmable limit.
- Runs on the system clock and advances on a 1 Hz `tick` pulse.
- Any button `activity` restarts the idle count.
- Drives the return-to-time-display logic through a warning level, a timeout level and a one-cycle timeout pulse.

---
 rtl/idle_watchdog_pkg.sv | 14 +
 rtl/idle_watchdog_if.sv | 24 ++
 rtl/idle_sec_counter.sv | 32 +++
 rtl/idle_watchdog.sv | 167 ++++++++++++++++
 tb/tb_idle_watchdog.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/idle_watchdog_pkg.sv
// Shared types and default constants for the alarm-clock idle watchdog.
package idle_watchdog_pkg;

    localparam int DEF_CNT_W    = 8;
    localparam int DEF_WARN_SEC = 5;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_COUNTING = 2'd1,
        ST_WARNING  = 2'd2,
        ST_EXPIRED  = 2'd3
    } wdState_e;

endpackage : idle_watchdog_pkg

// File: rtl/idle_watchdog_if.sv
// Control and status bundle between the button/tick logic and the idle watchdog.
interface idle_watchdog_if #(
    parameter int CNT_W = idle_watchdog_pkg::DEF_CNT_W
);
    logic             tick;
    logic             activity;
    logic             arm;
    logic [CNT_W-1:0] timeout_sec;
    logic [CNT_W-1:0] idle_secs;
    logic [CNT_W-1:0] remaining;
    logic             warn;
    logic             timeout;
    logic             timeout_pulse;

    modport master (
        output tick, activity, arm, timeout_sec,
        input  idle_secs, remaining, warn, timeout, timeout_pulse
    );

    modport slave (
        input  tick, activity, arm, timeout_sec,
        output idle_secs, remaining, warn, timeout, timeout_pulse
    );
endinterface : idle_watchdog_if

// File: rtl/idle_sec_counter.sv
// Idle-seconds up-counter: synchronous clear wins, increments saturate at the compare value.
module idle_sec_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             atLimit
);

    logic [CNT_W-1:0] countR;

    // Count register: clear has priority, increment only below the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countR <= {CNT_W{1'b0}};
        end else if (clr) begin
            countR <= {CNT_W{1'b0}};
        end else if (inc && (countR != limit)) begin
            countR <= countR + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            countR <= countR;
        end
    end

    assign count   = countR;
    assign atLimit = (countR == limit);

endmodule : idle_sec_counter

// File: rtl/idle_watchdog.sv
// Idle watchdog: counts seconds without button activity and flags warning/timeout.
module idle_watchdog
    import idle_watchdog_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WARN_SEC = DEF_WARN_SEC
) (
    input  logic          clk,
    input  logic          rst_n,
    idle_watchdog_if.slave bus
);

    localparam logic [CNT_W-1:0] WARN_LIM = CNT_W'(WARN_SEC);
    localparam logic [CNT_W-1:0] ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    wdState_e         state;
    wdState_e         nextState;
    wdState_e         restartState;
    logic [CNT_W-1:0] limitReg;
    logic [CNT_W-1:0] idleCnt;
    logic [CNT_W-1:0] newIdle;
    logic [CNT_W-1:0] newRem;
    logic             atLimit;
    logic             cntClr;
    logic             cntInc;
    logic             limitLoad;
    logic             limitClr;
    logic             warnReg;
    logic             timeoutReg;
    logic             pulseReg;
    logic             warnNext;
    logic             timeoutNext;
    logic             pulseNext;

    idle_sec_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cntClr),
        .inc     (cntInc),
        .limit   (limitReg),
        .count   (idleCnt),
        .atLimit (atLimit)
    );

    // Latched limit: cleared whenever disarmed, loaded only on the arming cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            limitReg <= {CNT_W{1'b0}};
        end else if (limitClr) begin
            limitReg <= {CNT_W{1'b0}};
        end else if (limitLoad) begin
            limitReg <= bus.timeout_sec;
        end else begin
            limitReg <= limitReg;
        end
    end

    // State register together with the registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_DISARMED;
            warnReg    <= 1'b0;
            timeoutReg <= 1'b0;
            pulseReg   <= 1'b0;
        end else begin
            state      <= nextState;
            warnReg    <= warnNext;
            timeoutReg <= timeoutNext;
            pulseReg   <= pulseNext;
        end
    end

    // Next-state logic; arm=0 dominates, then activity, then tick.
    always_comb begin
        nextState    = state;
        cntClr       = 1'b0;
        cntInc       = 1'b0;
        limitLoad    = 1'b0;
        limitClr     = 1'b0;
        newIdle      = idleCnt + ONE;
        newRem       = limitReg - newIdle;
        restartState = (limitReg <= WARN_LIM) ? ST_WARNING : ST_COUNTING;
        if (!bus.arm) begin
            nextState = ST_DISARMED;
            cntClr    = 1'b1;
            limitClr  = 1'b1;
        end else begin
            case (state)
                ST_DISARMED: begin
                    cntClr = 1'b1;
                    // A zero limit keeps the watchdog disabled even while armed.
                    if (bus.timeout_sec != {CNT_W{1'b0}}) begin
                        limitLoad = 1'b1;
                        nextState = (bus.timeout_sec <= WARN_LIM) ? ST_WARNING : ST_COUNTING;
                    end else begin
                        limitClr  = 1'b1;
                        nextState = ST_DISARMED;
                    end
                end
                ST_COUNTING, ST_WARNING: begin
                    if (bus.activity) begin
                        cntClr    = 1'b1;
                        nextState = restartState;
                    end else if (bus.tick && !atLimit) begin
                        cntInc = 1'b1;
                        if (newIdle == limitReg) begin
                            nextState = ST_EXPIRED;
                        end else if (newRem <= WARN_LIM) begin
                            nextState = ST_WARNING;
                        end else begin
                            nextState = state;
                        end
                    end else begin
                        nextState = state;
                    end
                end
                ST_EXPIRED: begin
                    if (bus.activity) begin
                        cntClr    = 1'b1;
                        nextState = restartState;
                    end else begin
                        nextState = ST_EXPIRED;
                    end
                end
                default: begin
                    nextState = ST_DISARMED;
                    cntClr    = 1'b1;
                    limitClr  = 1'b1;
                end
            endcase
        end
    end

    // Output decode of the upcoming state, registered alongside it.
    always_comb begin
        warnNext    = 1'b0;
        timeoutNext = 1'b0;
        pulseNext   = 1'b0;
        case (nextState)
            ST_WARNING: begin
                warnNext = 1'b1;
            end
            ST_EXPIRED: begin
                timeoutNext = 1'b1;
                pulseNext   = (state != ST_EXPIRED);
            end
            ST_DISARMED, ST_COUNTING: begin
                warnNext    = 1'b0;
                timeoutNext = 1'b0;
            end
            default: begin
                warnNext    = 1'b0;
                timeoutNext = 1'b0;
                pulseNext   = 1'b0;
            end
        endcase
    end

    assign bus.idle_secs     = idleCnt;
    assign bus.remaining     = limitReg - idleCnt;
    assign bus.warn          = warnReg;
    assign bus.timeout       = timeoutReg;
    assign bus.timeout_pulse = pulseReg;

endmodule : idle_watchdog

// File: tb/tb_idle_watchdog.sv
// Directed bench for idle_watchdog with hand-computed expectations.
module tb_idle_watchdog;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    idle_watchdog_if #(.CNT_W(8)) busIf ();

    idle_watchdog #(
        .CNT_W    (8),
        .WARN_SEC (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock with the given tick/activity, then sample 1 time unit after the edge.
    task automatic doCycle(input logic t, input logic a);
        busIf.tick     = t;
        busIf.activity = a;
        @(posedge clk);
        #1;
        busIf.tick     = 1'b0;
        busIf.activity = 1'b0;
    endtask

    task automatic checkAll(input string tag, input int idle, input int rem,
                            input int w, input int to, input int p);
        checkVal({tag, "_idle"}, 32'(busIf.idle_secs), 32'(idle));
        checkVal({tag, "_rem"},  32'(busIf.remaining), 32'(rem));
        checkVal({tag, "_warn"}, 32'(busIf.warn), 32'(w));
        checkVal({tag, "_to"},   32'(busIf.timeout), 32'(to));
        checkVal({tag, "_pls"},  32'(busIf.timeout_pulse), 32'(p));
    endtask

    task automatic armWith(input logic [7:0] lim);
        busIf.arm = 1'b0;
        doCycle(1'b0, 1'b0);
        busIf.timeout_sec = lim;
        busIf.arm         = 1'b1;
    endtask

    initial begin
        int sawTimeout;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        busIf.tick        = 1'b0;
        busIf.activity    = 1'b0;
        busIf.arm         = 1'b0;
        busIf.timeout_sec = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Basic expiry with limit 10; tick in the arming cycle is not counted.
        armWith(8'd10);
        doCycle(1'b1, 1'b0);
        checkAll("arm10", 0, 10, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            doCycle(1'b1, 1'b0);
            checkAll($sformatf("t%0d", i), i, 10 - i,
                     (i >= 5 && i < 10) ? 1 : 0, (i == 10) ? 1 : 0, (i == 10) ? 1 : 0);
        end
        doCycle(1'b1, 1'b0);
        checkAll("exp_hold1", 10, 0, 0, 1, 0);
        doCycle(1'b1, 1'b0);
        checkAll("exp_hold2", 10, 0, 0, 1, 0);

        // Disarm from EXPIRED, then re-arm with limit 4 (starts in WARNING).
        busIf.arm = 1'b0;
        doCycle(1'b0, 1'b0);
        checkAll("disarm_exp", 0, 0, 0, 0, 0);
        busIf.timeout_sec = 8'd4;
        busIf.arm         = 1'b1;
        doCycle(1'b0, 1'b0);
        checkAll("arm4", 0, 4, 1, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            doCycle(1'b1, 1'b0);
        end
        checkAll("exp4", 4, 0, 0, 1, 1);

        // Activity after 7 ticks restarts the full 10 s window.
        armWith(8'd10);
        doCycle(1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            doCycle(1'b1, 1'b0);
        end
        checkAll("t7", 7, 3, 1, 0, 0);
        doCycle(1'b0, 1'b1);
        checkAll("act7", 0, 10, 0, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            doCycle(1'b1, 1'b0);
        end
        checkAll("re9", 9, 1, 1, 0, 0);
        doCycle(1'b1, 1'b0);
        checkAll("re10", 10, 0, 0, 1, 1);

        // Activity from EXPIRED, then tick+activity together at 3; limit change ignored.
        doCycle(1'b0, 1'b1);
        checkAll("act_exp", 0, 10, 0, 0, 0);
        busIf.timeout_sec = 8'd2;
        for (int i = 1; i <= 3; i++) begin
            doCycle(1'b1, 1'b0);
        end
        checkAll("pre_both", 3, 7, 0, 0, 0);
        doCycle(1'b1, 1'b1);
        checkAll("both", 0, 10, 0, 0, 0);

        // Short limit 3 warns immediately after arming.
        armWith(8'd3);
        doCycle(1'b0, 1'b0);
        checkAll("arm3", 0, 3, 1, 0, 0);

        // Zero limit: watchdog stays disarmed through 300 ticks.
        armWith(8'd0);
        sawTimeout = 0;
        for (int i = 0; i < 300; i++) begin
            doCycle(1'b1, 1'b0);
            if (busIf.timeout || busIf.timeout_pulse || busIf.warn) sawTimeout = 1;
        end
        checkVal("zero_noto", 32'(sawTimeout), 32'd0);
        checkAll("zero_end", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-count clears everything before the next edge.
        armWith(8'd10);
        doCycle(1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            doCycle(1'b1, 1'b0);
        end
        checkAll("t6", 6, 4, 1, 0, 0);
        #2;
        rst_n     = 1'b0;
        busIf.arm = 1'b0;
        #1;
        checkAll("async_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        doCycle(1'b1, 1'b0);
        checkAll("post_rst", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_idle_watchdog
